// File: rtl/power_monitor_mux.sv
// Multi-rail power monitor: sequences a comparator mux, debounces per-comparator
// undervolt/overvolt faults after grace periods, and latches fault status until acked.
module power_monitor_mux #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned SEL_W         = 4,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned OV_GRACE      = 10,
  parameter int unsigned UV_GRACE      = 50000,
  parameter int unsigned DEBOUNCE      = 2,
  parameter int unsigned AUTO_KILL     = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [NUM_CH-1:0]     ch_mask_i,
  input  logic                  data_i,
  input  logic                  ack_i,
  output logic                  kill_sw_o,
  output logic [SEL_W-1:0]      sel_o,
  output logic                  error_o,
  output logic [2*NUM_CH-1:0]   fault_status_o,
  output logic                  scan_done_o
);

  localparam int unsigned NC    = 2 * NUM_CH;
  localparam int unsigned WaitW = $clog2(SETTLE_CYCLES);
  localparam int unsigned OvW   = (OV_GRACE > 0) ? $clog2(OV_GRACE + 1) : 1;
  localparam int unsigned UvW   = (UV_GRACE > 0) ? $clog2(UV_GRACE + 1) : 1;
  localparam int unsigned FcW   = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StFault} state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              kill_q, kill_d;
  logic              error_q, error_d;
  logic [NC-1:0]     fault_q, fault_d;
  logic              done_q, done_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [OvW-1:0]    ov_q, ov_d;
  logic [UvW-1:0]    uv_q, uv_d;
  logic [FcW-1:0]    fail_cnt_q [NC];
  logic [FcW-1:0]    fail_cnt_d [NC];

  logic              mask_bit;
  logic              fail;
  logic              fault_hit;
  logic              is_last;
  logic [FcW-1:0]    cur_cnt;
  logic [FcW-1:0]    new_cnt;

  // Evaluation of the comparator currently selected by sel_q.
  always_comb begin
    mask_bit = 1'b0;
    cur_cnt  = '0;
    for (int r = 0; r < int'(NUM_CH); r++) begin
      if ((int'(sel_q) >> 1) == r) mask_bit = ch_mask_i[r];
    end
    for (int i = 0; i < int'(NC); i++) begin
      if (int'(sel_q) == i) cur_cnt = fail_cnt_q[i];
    end
    fail = mask_bit & ((~sel_q[0] & ~data_i & (uv_q == '0)) |
                       ( sel_q[0] &  data_i & (ov_q == '0)));
    if (!fail) begin
      new_cnt = '0;
    end else if (cur_cnt == FcW'(DEBOUNCE)) begin
      new_cnt = cur_cnt;
    end else begin
      new_cnt = cur_cnt + 1'b1;
    end
    fault_hit = fail && (new_cnt == FcW'(DEBOUNCE));
    is_last   = (sel_q == SEL_W'(NC - 1));
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    kill_d     = kill_q;
    error_d    = error_q;
    fault_d    = fault_q;
    done_d     = 1'b0;
    wait_d     = wait_q;
    ov_d       = ov_q;
    uv_d       = uv_q;
    fail_cnt_d = fail_cnt_q;

    if (!start_i) begin
      state_d = StIdle;
      sel_d   = '1;
      kill_d  = 1'b0;
      error_d = 1'b0;
      fault_d = '0;
      wait_d  = '0;
      ov_d    = OvW'(OV_GRACE);
      uv_d    = UvW'(UV_GRACE);
      for (int i = 0; i < int'(NC); i++) fail_cnt_d[i] = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StSettle;
          sel_d   = '0;
          kill_d  = 1'b1;
          wait_d  = '0;
          ov_d    = OvW'(OV_GRACE);
          uv_d    = UvW'(UV_GRACE);
          for (int i = 0; i < int'(NC); i++) fail_cnt_d[i] = '0;
        end
        StSettle: begin
          wait_d = wait_q + 1'b1;
          if (wait_q == WaitW'(SETTLE_CYCLES - 1)) state_d = StSample;
        end
        StSample: begin
          for (int i = 0; i < int'(NC); i++) begin
            if (int'(sel_q) == i) fail_cnt_d[i] = new_cnt;
          end
          if (fault_hit) begin
            // sel and grace counters freeze so the host sees the offending comparator.
            state_d = StFault;
            error_d = 1'b1;
            kill_d  = (AUTO_KILL == 0);
            for (int i = 0; i < int'(NC); i++) begin
              if (int'(sel_q) == i) fault_d[i] = 1'b1;
            end
          end else begin
            state_d = StSettle;
            wait_d  = '0;
            if (is_last) begin
              sel_d  = '0;
              done_d = 1'b1;
              if (ov_q != '0) ov_d = ov_q - 1'b1;
              if (uv_q != '0) uv_d = uv_q - 1'b1;
            end else begin
              sel_d = sel_q + 1'b1;
            end
          end
        end
        StFault: begin
          if (ack_i) begin
            state_d = StSettle;
            error_d = 1'b0;
            fault_d = '0;
            sel_d   = '0;
            kill_d  = 1'b1;
            wait_d  = '0;
            ov_d    = OvW'(OV_GRACE);
            uv_d    = UvW'(UV_GRACE);
            for (int i = 0; i < int'(NC); i++) fail_cnt_d[i] = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      sel_q   <= '1;
      kill_q  <= 1'b0;
      error_q <= 1'b0;
      fault_q <= '0;
      done_q  <= 1'b0;
      wait_q  <= '0;
      ov_q    <= '0;
      uv_q    <= '0;
      for (int i = 0; i < int'(NC); i++) fail_cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      kill_q     <= kill_d;
      error_q    <= error_d;
      fault_q    <= fault_d;
      done_q     <= done_d;
      wait_q     <= wait_d;
      ov_q       <= ov_d;
      uv_q       <= uv_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign kill_sw_o      = kill_q;
  assign sel_o          = sel_q;
  assign error_o        = error_q;
  assign fault_status_o = fault_q;
  assign scan_done_o    = done_q;

endmodule
